shifter_pipelined: RTL and testbench

- Parametrised, pipelined barrel shifter for the RISC-V execute path.
- Supports four modes: logical left, logical right, arithmetic right and rotate right.
- Uses one register stage per shift level, with valid/ready handshakes on both sides and bubble-collapsing backpressure.
- Replaces the single-mode combinational shifter wherever a shift unit must meet timing across a multi-cycle execute unit.

---
 rtl/shifter_pipelined.sv | 138 +++++++++++++
 tb/tb_shifter_pipelined.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter: one register stage per shift-amount bit.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROR. Valid/ready on both sides, and
// empty stages keep filling during a stall, so bubbles collapse.
module shifter_pipelined #(
   parameter int nb_bits_data  = 32,
   parameter int nb_bits_shift = 5,
   parameter int nb_bits_tag   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [nb_bits_data-1:0]  data_i,
   input  logic [nb_bits_shift-1:0] shift_value_i,
   input  logic [1:0]               mode_i,
   input  logic [nb_bits_tag-1:0]   tag_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [nb_bits_data-1:0]  data_o,
   output logic [nb_bits_tag-1:0]   tag_o
);

   localparam int n_stages = nb_bits_shift;

   localparam logic [1:0] mode_sll = 2'b00;
   localparam logic [1:0] mode_srl = 2'b01;
   localparam logic [1:0] mode_sra = 2'b10;

   // Per-stage registers. The full shift amount travels with the operation;
   // stage k only looks at bit k of it.
   logic [nb_bits_data-1:0]  data_q  [n_stages];
   logic [nb_bits_shift-1:0] shamt_q [n_stages];
   logic [1:0]               mode_q  [n_stages];
   logic                     sign_q  [n_stages];
   logic [nb_bits_tag-1:0]   tag_q   [n_stages];
   logic [n_stages-1:0]      valid_q;

   // Values presented to each stage (stage 0 from the inputs, others from k-1)
   logic [nb_bits_data-1:0]  src_data  [n_stages];
   logic [nb_bits_shift-1:0] src_shamt [n_stages];
   logic [1:0]               src_mode  [n_stages];
   logic                     src_sign  [n_stages];
   logic [nb_bits_tag-1:0]   src_tag   [n_stages];
   logic [n_stages-1:0]      src_valid;
   logic [nb_bits_data-1:0]  nxt_data  [n_stages];
   logic [n_stages-1:0]      load;

   // One shift step by a fixed power of two; amt is always in 1..nb_bits_data/2,
   // so the complementary shift for the fill never reaches the full width.
   function automatic logic [nb_bits_data-1:0] shift_step(
      input logic [nb_bits_data-1:0] d,
      input logic [1:0]              mode,
      input logic                    sign,
      input int                      amt
   );
      logic [nb_bits_data-1:0] r;
      case (mode)
         mode_sll: r = d << amt;
         mode_srl: r = d >> amt;
         mode_sra: r = (d >> amt) | ({nb_bits_data{sign}} << (nb_bits_data - amt));
         default:  r = (d >> amt) | (d << (nb_bits_data - amt));
      endcase
      return r;
   endfunction

   // Advance chain, resolved from the last stage back to stage 0
   always_comb begin
      logic ld;
      load = '0;
      ld   = !valid_q[n_stages-1] || out_ready_i;
      load[n_stages-1] = ld;
      for (int k = n_stages - 2; k >= 0; k--) begin
         ld      = !valid_q[k] || ld;
         load[k] = ld;
      end
   end

   assign in_ready_o = load[0] && !flush_i;

   // Stage inputs and the shifted value each stage would register
   always_comb begin
      src_data[0]  = data_i;
      src_shamt[0] = shift_value_i;
      src_mode[0]  = mode_i;
      src_sign[0]  = data_i[nb_bits_data-1];
      src_tag[0]   = tag_i;
      src_valid    = '0;
      src_valid[0] = in_valid_i && in_ready_o;
      for (int k = 1; k < n_stages; k++) begin
         src_data[k]  = data_q[k-1];
         src_shamt[k] = shamt_q[k-1];
         src_mode[k]  = mode_q[k-1];
         src_sign[k]  = sign_q[k-1];
         src_tag[k]   = tag_q[k-1];
         src_valid[k] = valid_q[k-1];
      end
      for (int k = 0; k < n_stages; k++) begin
         nxt_data[k] = src_shamt[k][k]
                     ? shift_step(src_data[k], src_mode[k], src_sign[k], 1 << k)
                     : src_data[k];
      end
   end

   // Stage registers; payload only updates when a valid operation moves in
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
         for (int k = 0; k < n_stages; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            mode_q[k]  <= '0;
            sign_q[k]  <= 1'b0;
            tag_q[k]   <= '0;
         end
      end else if (flush_i) begin
         valid_q <= '0;
      end else begin
         for (int k = 0; k < n_stages; k++) begin
            if (load[k]) begin
               valid_q[k] <= src_valid[k];
               if (src_valid[k]) begin
                  data_q[k]  <= nxt_data[k];
                  shamt_q[k] <= src_shamt[k];
                  mode_q[k]  <= src_mode[k];
                  sign_q[k]  <= src_sign[k];
                  tag_q[k]   <= src_tag[k];
               end
            end
         end
      end
   end

   assign out_valid_o = valid_q[n_stages-1];
   assign data_o      = data_q[n_stages-1];
   assign tag_o       = tag_q[n_stages-1];

endmodule

// File: tb/tb_shifter_pipelined.sv
// Directed bench for shifter_pipelined (32-bit data, 5 stages, 4-bit tag).
module tb_shifter_pipelined;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        flush_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] data_i;
   logic [4:0]  shift_value_i;
   logic [1:0]  mode_i;
   logic [3:0]  tag_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] data_o;
   logic [3:0]  tag_o;

   int checks   = 0;
   int failures = 0;

   shifter_pipelined #(
      .nb_bits_data  (32),
      .nb_bits_shift (5),
      .nb_bits_tag   (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .flush_i       (flush_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .data_i        (data_i),
      .shift_value_i (shift_value_i),
      .mode_i        (mode_i),
      .tag_i         (tag_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .data_o        (data_o),
      .tag_o         (tag_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                             input logic [1:0] m);
      logic [31:0] r;
      case (m)
         2'd0: r = d << s;
         2'd1: r = d >> s;
         2'd2: r = $unsigned($signed(d) >>> s);
         default: r = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
      endcase
      return r;
   endfunction

   // One isolated operation: result must appear exactly 5 edges after acceptance
   task automatic single(input string name, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] m, input logic [3:0] t, input logic [31:0] exp);
      @(negedge clk_i);
      data_i = d; shift_value_i = s; mode_i = m; tag_i = t; in_valid_i = 1'b1;
      chk({name, "_in_ready"}, {31'd0, in_ready_o}, 32'd1);
      @(negedge clk_i);
      in_valid_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk({name, "_early"}, {31'd0, out_valid_o}, 32'd0);
      @(negedge clk_i);
      chk({name, "_valid"}, {31'd0, out_valid_o}, 32'd1);
      chk({name, "_data"}, data_o, exp);
      chk({name, "_tag"}, {28'd0, tag_o}, {28'd0, t});
      @(negedge clk_i);
   endtask

   logic [31:0] st_d   [20];
   logic [4:0]  st_s   [20];
   logic [1:0]  st_m   [20];
   logic [31:0] st_exp [20];
   logic [31:0] bp_d   [7];
   logic [4:0]  bp_s   [7];
   logic [1:0]  bp_m   [7];
   logic [31:0] bp_exp [7];

   initial begin
      int tx, rx, seen;
      rst_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      data_i = '0; shift_value_i = '0; mode_i = '0; tag_i = '0;

      // Reset state
      #1;
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_tag", {28'd0, tag_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

      // Directed single operations
      single("sll31",  32'h0000_0001, 5'd31, 2'd0, 4'h5, 32'h8000_0000);
      single("sra4",   32'h8000_00F0, 5'd4,  2'd2, 4'h3, 32'hF800_000F);
      single("srl4",   32'h8000_00F0, 5'd4,  2'd1, 4'h6, 32'h0800_000F);
      single("sra0",   32'h8000_00F0, 5'd0,  2'd2, 4'h1, 32'h8000_00F0);
      single("ror8",   32'h1234_5678, 5'd8,  2'd3, 4'h9, 32'h7812_3456);
      single("sll0",   32'h1234_5678, 5'd0,  2'd0, 4'hF, 32'h1234_5678);
      single("ror31",  32'h0000_0001, 5'd31, 2'd3, 4'h2, 32'h0000_0002);
      single("sra31",  32'h8000_0000, 5'd31, 2'd2, 4'hC, 32'hFFFF_FFFF);
      single("srl31",  32'h8000_0000, 5'd31, 2'd1, 4'h7, 32'h0000_0001);
      single("ror1",   32'h8000_0001, 5'd1,  2'd3, 4'h0, 32'hC000_0000);

      // Streaming: 20 back-to-back operations, one result per cycle
      for (int i = 0; i < 20; i++) begin
         st_d[i]   = $urandom;
         st_s[i]   = 5'($urandom_range(0, 31));
         st_m[i]   = 2'(i % 4);
         st_exp[i] = ref_shift(st_d[i], st_s[i], st_m[i]);
      end
      for (int c = 0; c < 26; c++) begin
         @(negedge clk_i);
         if (c >= 5 && c < 25) begin
            chk($sformatf("stream%0d_valid", c - 5), {31'd0, out_valid_o}, 32'd1);
            chk($sformatf("stream%0d_data", c - 5), data_o, st_exp[c-5]);
            chk($sformatf("stream%0d_tag", c - 5), {28'd0, tag_o}, 32'((c - 5) % 16));
         end
         if (c < 20) begin
            data_i = st_d[c]; shift_value_i = st_s[c]; mode_i = st_m[c];
            tag_i = 4'(c); in_valid_i = 1'b1;
            chk($sformatf("stream%0d_in_ready", c), {31'd0, in_ready_o}, 32'd1);
         end else begin
            in_valid_i = 1'b0;
         end
      end

      // Backpressure: push 7 with the consumer stalled
      for (int i = 0; i < 7; i++) begin
         bp_d[i]   = 32'hA5C3_0F01 + 32'(i * 32'h0101_0101);
         bp_s[i]   = 5'(3 * i + 1);
         bp_m[i]   = 2'((i + 1) % 4);
         bp_exp[i] = ref_shift(bp_d[i], bp_s[i], bp_m[i]);
      end
      @(negedge clk_i);
      out_ready_i = 1'b0;
      tx = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         data_i = bp_d[tx]; shift_value_i = bp_s[tx]; mode_i = bp_m[tx];
         tag_i = 4'(tx + 8); in_valid_i = 1'b1;
         #1;
         if (in_ready_o) tx++;
      end
      chk("bp_accepted", 32'(tx), 32'd5);
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_hold_data", data_o, bp_exp[0]);
      @(negedge clk_i);
      chk("bp_stable_data", data_o, bp_exp[0]);
      chk("bp_stable_tag", {28'd0, tag_o}, 32'd8);
      chk("bp_stable_in_ready", {31'd0, in_ready_o}, 32'd0);

      out_ready_i = 1'b1;
      #1;
      rx = 0;
      for (int c = 0; c < 15; c++) begin
         if (out_valid_o) begin
            if (rx < 7) begin
               chk($sformatf("bp_out%0d_data", rx), data_o, bp_exp[rx]);
               chk($sformatf("bp_out%0d_tag", rx), {28'd0, tag_o}, 32'(rx + 8));
            end
            rx++;
         end
         if (tx < 7) begin
            data_i = bp_d[tx]; shift_value_i = bp_s[tx]; mode_i = bp_m[tx];
            tag_i = 4'(tx + 8); in_valid_i = 1'b1;
            if (in_ready_o) tx++;
         end else begin
            in_valid_i = 1'b0;
         end
         @(negedge clk_i);
         #1;
      end
      in_valid_i = 1'b0;
      chk("bp_results", 32'(rx), 32'd7);
      chk("bp_total_accepted", 32'(tx), 32'd7);

      // Flush with three operations in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         data_i = 32'hDEAD_0000 | 32'(i); shift_value_i = 5'd0; mode_i = 2'd0;
         tag_i = 4'(i); in_valid_i = 1'b1;
      end
      @(negedge clk_i);
      data_i = 32'hBEEF_0000; flush_i = 1'b1; in_valid_i = 1'b1;
      #1;
      chk("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0; in_valid_i = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (out_valid_o) seen++;
      end
      chk("flush_no_leak", 32'(seen), 32'd0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         data_i = 32'hFFFF_FFFF; shift_value_i = 5'd0; mode_i = 2'd0;
         tag_i = 4'hA; in_valid_i = 1'b1;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      chk("prerst_valid", {31'd0, out_valid_o}, 32'd1);
      chk("prerst_data", data_o, 32'hFFFF_FFFF);
      #2;
      rst_n_i = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("async_rst_data", data_o, 32'd0);
      chk("async_rst_tag", {28'd0, tag_o}, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      seen = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (out_valid_o) seen++;
      end
      chk("post_rst_no_output", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
